// File: rtl/updown_bounce_ctrl.sv
// Direction/clear sequencer that bounces a 4-bit up/down counter between limits.
// Optional low-turn counter on bounce_cnt is enabled with `define BOUNCE_CNT_EN.
module updown_bounce_ctrl #(
   parameter int WIDTH  = 4,
   parameter int BCNT_W = 8
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              enable,
   input  logic [WIDTH-1:0]  lo_limit,
   input  logic [WIDTH-1:0]  hi_limit,
   input  logic [WIDTH-1:0]  cnt_in,
   output logic              up_or_DownBar,
   output logic              cntr_clear,
   output logic              turn,
   output logic              cfg_err,
   output logic [BCNT_W-1:0] bounce_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN_UP   = 2'd1,
      RUN_DOWN = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] lo_q, hi_q;
   logic             up_q, clr_q, turn_q, err_q;

   // Compares run one bit wider so lo+1/lo+2/hi-1 never wrap.
   logic [WIDTH:0] lo_ext, hi_ext, cnt_ext;
   logic           lim_ok, at_top, at_bot;

   assign lo_ext  = {1'b0, lo_limit};
   assign hi_ext  = {1'b0, hi_limit};
   assign cnt_ext = {1'b0, cnt_in};
   assign lim_ok  = hi_ext >= (lo_ext + (WIDTH+1)'(2));
   assign at_top  = cnt_ext >= ({1'b0, hi_q} - (WIDTH+1)'(1));
   assign at_bot  = cnt_ext <= ({1'b0, lo_q} + (WIDTH+1)'(1));

`ifdef BOUNCE_CNT_EN
   logic [BCNT_W-1:0] bcnt_q;
   assign bounce_cnt = bcnt_q;
`else
   assign bounce_cnt = '0;
`endif

   always_ff @(posedge clk) begin
      if (!clear) begin
         state_q <= IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
         up_q    <= 1'b1;
         clr_q   <= 1'b0;
         turn_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef BOUNCE_CNT_EN
         bcnt_q  <= '0;
`endif
      end else begin
         turn_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               up_q  <= 1'b1;
               clr_q <= 1'b0;
               if (enable) begin
                  if (lim_ok) begin
                     state_q <= RUN_UP;
                     lo_q    <= lo_limit;
                     hi_q    <= hi_limit;
                     clr_q   <= 1'b1;
                     err_q   <= 1'b0;
                  end else begin
                     err_q   <= 1'b1;
                  end
               end
            end
            RUN_UP: begin
               if (!enable) begin
                  state_q <= IDLE;
                  clr_q   <= 1'b0;
                  up_q    <= 1'b1;
               end else if (at_top) begin
                  state_q <= RUN_DOWN;
                  up_q    <= 1'b0;
                  turn_q  <= 1'b1;
               end
            end
            RUN_DOWN: begin
               if (!enable) begin
                  state_q <= IDLE;
                  clr_q   <= 1'b0;
                  up_q    <= 1'b1;
               end else if (at_bot) begin
                  state_q <= RUN_UP;
                  up_q    <= 1'b1;
                  turn_q  <= 1'b1;
`ifdef BOUNCE_CNT_EN
                  if (bcnt_q != '1) bcnt_q <= bcnt_q + 1'b1;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               up_q    <= 1'b1;
               clr_q   <= 1'b0;
            end
         endcase
      end
   end

   assign up_or_DownBar = up_q;
   assign cntr_clear    = clr_q;
   assign turn          = turn_q;
   assign cfg_err       = err_q;

endmodule

// File: tb/tb_updown_bounce_ctrl.sv
// Directed bench for updown_bounce_ctrl with a behavioural 4-bit up/down counter.
// Expected sequences are hand-derived tables.
module tb_updown_bounce_ctrl;

   logic       clk = 1'b0;
   logic       clear, enable;
   logic [3:0] lo_limit, hi_limit;
   logic       up_or_DownBar, cntr_clear, turn, cfg_err;
   logic [7:0] bounce_cnt;
   logic [3:0] q = 4'd0;

   int checks   = 0;
   int failures = 0;

   updown_bounce_ctrl #(.WIDTH(4), .BCNT_W(8)) dut (
      .clk           (clk),
      .clear         (clear),
      .enable        (enable),
      .lo_limit      (lo_limit),
      .hi_limit      (hi_limit),
      .cnt_in        (q),
      .up_or_DownBar (up_or_DownBar),
      .cntr_clear    (cntr_clear),
      .turn          (turn),
      .cfg_err       (cfg_err),
      .bounce_cnt    (bounce_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cntr_clear !== 1'b1) q <= 4'd0;
      else if (up_or_DownBar)  q <= q + 4'd1;
      else                     q <= q - 4'd1;
   end

`ifdef BOUNCE_CNT_EN
   localparam int BC1 = 1;
`else
   localparam int BC1 = 0;
`endif

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int exp_q  [24] = '{0,1,2,3,4,5,6,7,8,9,8,7,
                       6,5,4,3,2,3,4,5,6,7,8,9};
   int exp_tn [24] = '{0,0,0,0,0,0,0,0,0,1,0,0,
                       0,0,0,0,1,0,0,0,0,0,0,1};

   initial begin
      clear = 1'b0; enable = 1'b1; lo_limit = 4'd2; hi_limit = 4'd9;
      // 1. reset
      tick(2);
      chk("rst_up",   up_or_DownBar, 1);
      chk("rst_clr",  cntr_clear, 0);
      chk("rst_turn", turn, 0);
      chk("rst_err",  cfg_err, 0);
      chk("rst_bcnt", bounce_cnt, 0);
      chk("rst_q",    q, 0);

      // 2. lo=2 hi=9 bounce
      clear = 1'b1;
      tick();
      chk("s2_clr", cntr_clear, 1);
      for (int i = 0; i < 24; i++) begin
         if (i > 0) tick();
         chk($sformatf("s2_q%0d", i), q, exp_q[i]);
         chk($sformatf("s2_turn%0d", i), turn, exp_tn[i]);
         if (i == 16) chk("s2_bcnt", bounce_cnt, BC1);
      end
      chk("s2_dir_end", up_or_DownBar, 0);

      // 3. invalid limits, then valid restart
      clear = 1'b0;
      tick();
      clear = 1'b1; lo_limit = 4'd4; hi_limit = 4'd5;
      tick();
      chk("s3_err", cfg_err, 1);
      chk("s3_clr", cntr_clear, 0);
      tick();
      chk("s3_err_hold", cfg_err, 1);
      chk("s3_q", q, 0);
      lo_limit = 4'd3; hi_limit = 4'd12;
      tick();
      chk("s3_err_clr", cfg_err, 0);
      chk("s3_run", cntr_clear, 1);
      tick();
      chk("s3_q1", q, 1);
      lo_limit = 4'd0; hi_limit = 4'd15;
      enable = 1'b0;
      tick(2);
      chk("s3_idle_q", q, 0);

      // 4. full range, no wrap
      enable = 1'b1;
      tick();
      tick(15);
      chk("s4_peak", q, 15);
      chk("s4_turn_hi", turn, 1);
      tick();
      chk("s4_nowrap", q, 14);
      chk("s4_turn0", turn, 0);
      tick(14);
      chk("s4_trough", q, 0);
      chk("s4_turn_lo", turn, 1);
      chk("s4_up", up_or_DownBar, 1);
      chk("s4_bcnt", bounce_cnt, BC1);
      tick();
      chk("s4_nowrap2", q, 1);

      // 5. enable drop in RUN_DOWN at q=7, then restart
      enable = 1'b0;
      tick(2);
      lo_limit = 4'd2; hi_limit = 4'd9;
      enable = 1'b1;
      tick();
      tick(11);
      chk("s5_q7", q, 7);
      chk("s5_dn", up_or_DownBar, 0);
      enable = 1'b0;
      tick();
      chk("s5_clr", cntr_clear, 0);
      chk("s5_up", up_or_DownBar, 1);
      chk("s5_turn", turn, 0);
      tick();
      chk("s5_q0", q, 0);
      enable = 1'b1;
      tick();
      tick();
      chk("s5_restart", q, 1);
      chk("s5_bcnt_keep", bounce_cnt, BC1);
      tick(7);
      chk("s5_q8", q, 8);
      enable = 1'b0;
      tick();
      chk("s5_prio_turn", turn, 0);
      chk("s5_prio_up", up_or_DownBar, 1);
      tick();
      chk("s5_prio_q", q, 0);

      // 6. reset mid-run at q=6 going up
      enable = 1'b1;
      tick();
      tick(6);
      chk("s6_q6", q, 6);
      clear = 1'b0;
      tick();
      chk("s6_up",   up_or_DownBar, 1);
      chk("s6_clr",  cntr_clear, 0);
      chk("s6_turn", turn, 0);
      chk("s6_err",  cfg_err, 0);
      chk("s6_bcnt", bounce_cnt, 0);
      tick();
      chk("s6_q", q, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
